// File: rtl/spart_echo_driver.sv
// spart_echo_driver
//   Bus master for the SPART peripheral. It programs the baud divisor
//   (low byte, then high byte) after reset and whenever the board switches
//   select a new rate. Otherwise it echoes received bytes back to the
//   transmitter through a small FIFO. When both a read and a write are
//   possible in the same cycle, it alternates between them.
//
// Parameters
//   CLK_FREQ_HZ  system clock frequency, used to derive the four divisors
//   FIFO_DEPTH   echo buffer depth in bytes (power of two, >= 2)
//   DIV_W        divisor width (<= 16, split across two byte writes)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-low reset
//   br_cfg      baud select from switches (00=4800 .. 11=38400), asynchronous
//   rda         SPART receive data available
//   tbr         SPART transmit buffer ready
//   iocs        chip select, one cycle per access
//   iorw        1 = read from SPART, 0 = write to SPART
//   ioaddr      00 = data, 10 = divisor low, 11 = divisor high
//   databus     bidirectional data, driven here only on writes
//   fifo_count  bytes currently buffered
//   prog_done   programmed divisor matches the synchronised switch setting
module spart_echo_driver #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_W       = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [1:0]                      br_cfg,
  input  logic                            rda,
  input  logic                            tbr,
  output logic                            iocs,
  output logic                            iorw,
  output logic [1:0]                      ioaddr,
  inout  wire  [7:0]                      databus,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            prog_done
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam int DIV_4800  = CLK_FREQ_HZ / (16 * 4800);
  localparam int DIV_9600  = CLK_FREQ_HZ / (16 * 9600);
  localparam int DIV_19200 = CLK_FREQ_HZ / (16 * 19200);
  localparam int DIV_38400 = CLK_FREQ_HZ / (16 * 38400);

  localparam logic [2:0] PROG_LO = 3'd0;
  localparam logic [2:0] PROG_HI = 3'd1;
  localparam logic [2:0] IDLE    = 3'd2;
  localparam logic [2:0] READ    = 3'd3;
  localparam logic [2:0] WRITE   = 3'd4;

  // Reject parameter sets whose divisors cannot be represented or are zero.
  generate
    if (DIV_W < 1 || DIV_W > 16) begin : g_bad_div_w
      $error("spart_echo_driver: DIV_W must be in 1..16");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("spart_echo_driver: FIFO_DEPTH must be a power of two >= 2");
    end
    if (DIV_4800 == 0 || DIV_9600 == 0 || DIV_19200 == 0 || DIV_38400 == 0) begin : g_div_zero
      $error("spart_echo_driver: a baud divisor evaluates to zero");
    end
    if (DIV_4800 >= (1 << DIV_W) || DIV_9600 >= (1 << DIV_W) ||
        DIV_19200 >= (1 << DIV_W) || DIV_38400 >= (1 << DIV_W)) begin : g_div_wide
      $error("spart_echo_driver: a baud divisor does not fit in DIV_W bits");
    end
  endgenerate

  function automatic logic [15:0] div_of(input logic [1:0] sel);
    case (sel)
      2'b00:   div_of = 16'(DIV_4800);
      2'b01:   div_of = 16'(DIV_9600);
      2'b10:   div_of = 16'(DIV_19200);
      default: div_of = 16'(DIV_38400);
    endcase
  endfunction

  logic [1:0]    sync1;
  logic [1:0]    br_sync;
  logic [1:0]    br_prog;
  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic          run;
  logic          last_rd;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [7:0]    bus_out;
  logic [15:0]   div_lo_src;
  logic [15:0]   div_hi_src;
  logic          full;
  logic          empty;
  logic          rd_ok;
  logic          wr_ok;
  logic          push;
  logic          pop;

  // The synchroniser is left out of reset so it keeps tracking the switches
  // while reset is held; the first programming pass after release then uses
  // the live setting instead of a stale 00 that would force a second pass.
  always_ff @(posedge clk) begin
    sync1   <= br_cfg;
    br_sync <= sync1;
  end

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign rd_ok = rda & ~full;
  assign wr_ok = tbr & ~empty;

  always_comb begin
    state_nxt = state;
    case (state)
      PROG_LO: state_nxt = PROG_HI;
      PROG_HI: state_nxt = IDLE;
      IDLE: begin
        if (br_sync != br_prog)  state_nxt = PROG_LO;
        else if (rd_ok && wr_ok) state_nxt = last_rd ? WRITE : READ;
        else if (rd_ok)          state_nxt = READ;
        else if (wr_ok)          state_nxt = WRITE;
      end
      READ:    state_nxt = IDLE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = PROG_LO;
    endcase
  end

  // 'run' holds the bus quiet for the reset cycle itself. The FSM sits in
  // PROG_LO during reset, and the first access appears one edge after
  // release.
  always_ff @(posedge clk) begin
    if (!rst) begin
      run     <= 1'b0;
      state   <= PROG_LO;
      br_prog <= 2'b00;
      last_rd <= 1'b0;
    end else if (!run) begin
      run <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == PROG_LO) br_prog <= br_sync;
      if (state_nxt == READ)       last_rd <= 1'b1;
      else if (state_nxt == WRITE) last_rd <= 1'b0;
    end
  end

  assign div_lo_src = div_of(br_sync);
  assign div_hi_src = div_of(br_prog);

  always_comb begin
    iocs    = 1'b0;
    iorw    = 1'b1;
    ioaddr  = 2'b00;
    bus_out = 8'h00;
    if (run) begin
      case (state)
        PROG_LO: begin
          iocs    = 1'b1;
          iorw    = 1'b0;
          ioaddr  = 2'b10;
          bus_out = div_lo_src[7:0];
        end
        PROG_HI: begin
          iocs    = 1'b1;
          iorw    = 1'b0;
          ioaddr  = 2'b11;
          bus_out = div_hi_src[15:8];
        end
        READ: begin
          iocs = 1'b1;
        end
        WRITE: begin
          iocs    = 1'b1;
          iorw    = 1'b0;
          bus_out = mem[rd_ptr];
        end
        default: ;
      endcase
    end
  end

  assign databus = (iocs && !iorw) ? bus_out : 8'hzz;

  assign push = run && (state == READ);
  assign pop  = run && (state == WRITE);

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        count  <= count + CW'(1);
      end else if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        count  <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= databus;
  end

  assign fifo_count = count;
  assign prog_done  = run && (state != PROG_LO) && (state != PROG_HI) &&
                      (br_sync == br_prog);

endmodule

// File: tb/tb_spart_echo_driver.sv
// tb_spart_echo_driver
//   Drives spart_echo_driver with a SPART-like responder and compares every
//   bus access against a queue-based model of the echo path and the
//   divisor formula.
module tb_spart_echo_driver;

  localparam int DEPTH  = 4;
  localparam int CLK_HZ = 50_000_000;
  localparam int CW     = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    br_cfg = 2'b01;
  logic          rda = 1'b0;
  logic          tbr = 1'b0;
  logic          iocs;
  logic          iorw;
  logic [1:0]    ioaddr;
  wire  [7:0]    databus;
  logic [CW-1:0] fifo_count;
  logic          prog_done;

  logic [7:0] rx_byte = 8'h00;
  bit         rda_en  = 1'b0;
  bit         pend_pop = 1'b0;
  logic [7:0] src_q[$];
  logic [7:0] model_q[$];
  int         ops[$];
  int         total = 0;
  int         bad   = 0;
  int         prev_kind = 0;
  int         nreads = 0;
  int         niocs  = 0;
  logic [1:0] lo_cfg = 2'b00;

  spart_echo_driver #(
    .CLK_FREQ_HZ(CLK_HZ),
    .FIFO_DEPTH (DEPTH),
    .DIV_W      (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .br_cfg    (br_cfg),
    .rda       (rda),
    .tbr       (tbr),
    .iocs      (iocs),
    .iorw      (iorw),
    .ioaddr    (ioaddr),
    .databus   (databus),
    .fifo_count(fifo_count),
    .prog_done (prog_done)
  );

  // SPART side of the bus: it returns the head received byte on a read.
  assign databus = (iocs && iorw) ? rx_byte : 8'hzz;

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int div_of(input logic [1:0] sel);
    int baud;
    baud = 4800 << sel;
    return CLK_HZ / (16 * baud);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    rx_byte = (src_q.size() > 0) ? src_q[0] : 8'h00;
    rda     = rda_en && (src_q.size() > 0);
  endtask

  task automatic applyStimulus(input bit r_en, input bit t, input int nbytes);
    rda_en = r_en;
    tbr    = t;
    for (int i = 0; i < nbytes; i++) src_q.push_back(8'($urandom));
    refresh();
  endtask

  // One clock cycle. Outputs are observed on the falling edge; every access
  // is checked against the model and then applied to it.
  task automatic tick();
    int kind;
    logic [7:0] dummy;
    @(negedge clk);
    if (pend_pop) begin
      dummy = src_q.pop_front();
      pend_pop = 1'b0;
    end
    kind = 0;
    if (!rst) model_q.delete();
    checkOutput("fifo_count", 32'(fifo_count), 32'(model_q.size()));
    if (iocs) begin
      niocs++;
      if (!iorw && ioaddr == 2'b10)      kind = 1;
      else if (!iorw && ioaddr == 2'b11) kind = 2;
      else if (iorw && ioaddr == 2'b00)  kind = 3;
      else if (!iorw && ioaddr == 2'b00) kind = 4;
      else                               kind = 5;
      checkOutput("legal_access", 32'(kind != 5), 32'(1));
      checkOutput("access_gap", 32'((prev_kind != 0) && !(prev_kind == 1 && kind == 2)), 32'(0));
      case (kind)
        1: begin
          lo_cfg = br_cfg;
          checkOutput("div_lo", 32'(databus), 32'(div_of(lo_cfg) % 256));
        end
        2: begin
          checkOutput("hi_after_lo", 32'(prev_kind), 32'(1));
          checkOutput("div_hi", 32'(databus), 32'(div_of(lo_cfg) / 256));
        end
        3: begin
          checkOutput("read_not_full", 32'(model_q.size() < DEPTH), 32'(1));
          model_q.push_back(rx_byte);
          pend_pop = 1'b1;
          nreads++;
          ops.push_back(3);
        end
        4: begin
          checkOutput("write_not_empty", 32'(model_q.size() > 0), 32'(1));
          if (model_q.size() > 0) begin
            checkOutput("echo_data", 32'(databus), 32'(model_q[0]));
            dummy = model_q.pop_front();
          end
          ops.push_back(4);
        end
        default: ;
      endcase
    end
    prev_kind = kind;
    refresh();
  endtask

  initial begin
    int n0;
    int waited;
    bit pd_seen_low;
    bit alt_ok;
    $display("[TB] start");
    refresh();
    repeat (3) tick();

    // Held in reset: bus released and nothing buffered.
    checkOutput("rst_iocs", 32'(iocs), 32'(0));
    checkOutput("rst_iorw", 32'(iorw), 32'(1));
    checkOutput("rst_ioaddr", 32'(ioaddr), 32'(0));
    checkOutput("rst_bus_hiz", 32'(databus === 8'hzz), 32'(1));
    checkOutput("rst_prog_done", 32'(prog_done), 32'(0));

    // Release: low then high divisor byte for 9600 baud.
    rst = 1'b1;
    n0 = niocs;
    tick();
    checkOutput("start_lo_cs", 32'(iocs), 32'(1));
    checkOutput("start_lo_addr", 32'(ioaddr), 32'(2));
    checkOutput("start_lo_data", 32'(databus), 32'(8'h45));
    checkOutput("start_lo_pd", 32'(prog_done), 32'(0));
    tick();
    checkOutput("start_hi_addr", 32'(ioaddr), 32'(3));
    checkOutput("start_hi_data", 32'(databus), 32'(8'h01));
    tick();
    checkOutput("start_pd", 32'(prog_done), 32'(1));
    repeat (5) tick();
    checkOutput("start_pulses", 32'(niocs - n0), 32'(2));

    // Switch change 01 -> 11 while idle.
    br_cfg = 2'b11;
    pd_seen_low = 1'b0;
    waited = 0;
    do begin
      tick();
      waited++;
      if (!iocs && !prog_done) pd_seen_low = 1'b1;
    end while (!iocs && waited < 4);
    checkOutput("reprog_started", 32'(iocs && ioaddr == 2'b10), 32'(1));
    checkOutput("reprog_pd_fell", 32'(pd_seen_low), 32'(1));
    checkOutput("reprog_lo_data", 32'(databus), 32'(8'h51));
    checkOutput("reprog_lo_pd", 32'(prog_done), 32'(0));
    tick();
    checkOutput("reprog_hi_data", 32'(databus), 32'(8'h00));
    checkOutput("reprog_hi_pd", 32'(prog_done), 32'(0));
    tick();
    checkOutput("reprog_pd", 32'(prog_done), 32'(1));
    repeat (2) tick();

    // Single echo: READ, IDLE, WRITE.
    src_q.push_back(8'hA5);
    applyStimulus(1'b1, 1'b1, 0);
    tick();
    checkOutput("echo_read", 32'(iocs && iorw && ioaddr == 2'b00), 32'(1));
    tick();
    checkOutput("echo_idle", 32'(iocs), 32'(0));
    checkOutput("echo_count1", 32'(fifo_count), 32'(1));
    tick();
    checkOutput("echo_write", 32'(iocs && !iorw && ioaddr == 2'b00), 32'(1));
    checkOutput("echo_a5", 32'(databus), 32'(8'hA5));
    tick();
    checkOutput("echo_count0", 32'(fifo_count), 32'(0));

    // Fill to depth with the transmitter blocked.
    n0 = nreads;
    applyStimulus(1'b1, 1'b0, 6);
    repeat (16) tick();
    checkOutput("full_reads", 32'(nreads - n0), 32'(DEPTH));
    checkOutput("full_count", 32'(fifo_count), 32'(DEPTH));
    n0 = niocs;
    repeat (6) tick();
    checkOutput("full_quiet", 32'(niocs - n0), 32'(0));
    checkOutput("full_rda_held", 32'(rda), 32'(1));
    applyStimulus(1'b1, 1'b1, 0);
    waited = 0;
    while ((src_q.size() > 0 || model_q.size() > 0) && waited < 100) begin
      tick();
      waited++;
    end
    checkOutput("full_drained", 32'(src_q.size() + model_q.size()), 32'(0));

    // Random traffic on rda/tbr with random bytes.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) src_q.push_back(8'($urandom));
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      tick();
    end
    applyStimulus(1'b1, 1'b1, 0);
    waited = 0;
    while ((src_q.size() > 0 || model_q.size() > 0) && waited < 200) begin
      tick();
      waited++;
    end
    checkOutput("rand_drained", 32'(src_q.size() + model_q.size()), 32'(0));
    repeat (2) tick();

    // Both ready with a non-empty FIFO: strict alternation, write first
    // because the last operation was a read.
    applyStimulus(1'b1, 1'b0, 2);
    repeat (8) tick();
    checkOutput("alt_preload", 32'(fifo_count), 32'(2));
    ops.delete();
    applyStimulus(1'b1, 1'b1, 10);
    waited = 0;
    while (ops.size() < 20 && waited < 80) begin
      tick();
      waited++;
    end
    checkOutput("alt_ops", 32'(ops.size() >= 20), 32'(1));
    alt_ok = (ops.size() >= 20);
    for (int i = 1; i < 20 && i < ops.size(); i++)
      if (ops[i] == ops[i-1]) alt_ok = 1'b0;
    checkOutput("alternation", 32'(alt_ok), 32'(1));
    checkOutput("alt_first_write", 32'((ops.size() > 0) ? ops[0] : 0), 32'(4));
    waited = 0;
    while ((src_q.size() > 0 || model_q.size() > 0) && waited < 100) begin
      tick();
      waited++;
    end

    // One-cycle reset with 3 bytes buffered.
    applyStimulus(1'b1, 1'b0, 3);
    repeat (10) tick();
    checkOutput("pre_rst_count", 32'(fifo_count), 32'(3));
    rst = 1'b0;
    tick();
    checkOutput("mid_rst_iocs", 32'(iocs), 32'(0));
    checkOutput("mid_rst_bus_hiz", 32'(databus === 8'hzz), 32'(1));
    checkOutput("mid_rst_count", 32'(fifo_count), 32'(0));
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 0);
    tick();
    checkOutput("post_rst_lo", 32'(iocs && !iorw && ioaddr == 2'b10), 32'(1));
    tick();
    checkOutput("post_rst_hi", 32'(iocs && !iorw && ioaddr == 2'b11), 32'(1));
    tick();
    checkOutput("post_rst_pd", 32'(prog_done), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
